// File: rtl/mtra_pkg.sv
`default_nettype none
// ============================================================================
// Module : mtra_pkg
// Brief  : Shared types and constants for the repeated-addition multiplier
//          controller.
// Rev    : 1.0  initial release
// ============================================================================
package mtra_pkg;

   // Default operand / data bus width; matches the datapath registers.
   localparam int MTRA_DATA_W = 16;

   // Controller sequencing states.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD_A = 3'd1,
      ST_LOAD_B = 3'd2,
      ST_ADD    = 3'd3,
      ST_DONE   = 3'd4
   } state_e;

endpackage : mtra_pkg
`default_nettype wire

// File: rtl/mtra_controller.sv
`default_nettype none
// ============================================================================
// Module : mtra_controller
// Brief  : Sequencer for the repeated-addition multiplier datapath. Accepts an
//          operand pair, loads A (clearing P), loads B, then steps
//          add/decrement until the datapath counter reaches zero or the
//          iteration limit is hit. Reports count and timeout error.
// Rev    : 1.0  initial release
// ============================================================================
module mtra_controller
   import mtra_pkg::*;
#(
   parameter int DATA_W   = MTRA_DATA_W,
   parameter int MAX_ITER = 65535
) (
   input  logic              clk,
   input  logic              rst_n,
   // request channel
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [DATA_W-1:0] a_in,
   input  logic [DATA_W-1:0] b_in,
   // response channel
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic              resp_err,
   output logic [DATA_W-1:0] iter_count,
   output logic              busy,
   // datapath interface
   output logic [DATA_W-1:0] data_out,
   output logic              ld_a,
   output logic              ld_b,
   output logic              ld_p,
   output logic              clr_p,
   output logic              dec_b,
   input  logic              eqz
);

   // Iteration limit expressed at counter width (MAX_ITER fits by contract).
   localparam logic [DATA_W-1:0] ITER_LIMIT = MAX_ITER[DATA_W-1:0];

   state_e            state_q;
   logic [DATA_W-1:0] b_q;
   logic [DATA_W-1:0] iter_count_q;
   logic [DATA_W-1:0] data_out_q;
   logic              ld_a_q;
   logic              clr_p_q;
   logic              ld_b_q;
   logic              resp_err_q;

   logic              at_limit_d;
   logic              add_step_d;

   // The add/decrement strobe must react to eqz in the same cycle, otherwise
   // the datapath would overshoot by one step; it is therefore decoded from
   // the registered state and registered counter plus the live eqz flag.
   always_comb begin
      at_limit_d = (iter_count_q == ITER_LIMIT);
      add_step_d = (state_q == ST_ADD) && !eqz && !at_limit_d;
   end

   // Sequencer: state, operand capture, load strobes, bus value, counter, error.
   // A is written straight into the bus register at the handshake, so only B
   // needs a separate holding register until LOAD_B.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         b_q          <= '0;
         iter_count_q <= '0;
         data_out_q   <= '0;
         ld_a_q       <= 1'b0;
         clr_p_q      <= 1'b0;
         ld_b_q       <= 1'b0;
         resp_err_q   <= 1'b0;
      end else begin
         // load strobes are single-cycle pulses by default
         ld_a_q  <= 1'b0;
         clr_p_q <= 1'b0;
         ld_b_q  <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (req_valid) begin
                  b_q          <= b_in;
                  iter_count_q <= '0;
                  data_out_q   <= a_in;
                  ld_a_q       <= 1'b1;
                  clr_p_q      <= 1'b1;
                  state_q      <= ST_LOAD_A;
               end
            end
            ST_LOAD_A: begin
               data_out_q <= b_q;
               ld_b_q     <= 1'b1;
               state_q    <= ST_LOAD_B;
            end
            ST_LOAD_B: begin
               state_q <= ST_ADD;
            end
            ST_ADD: begin
               // counter reaching zero wins over the iteration limit
               if (eqz) begin
                  resp_err_q <= 1'b0;
                  state_q    <= ST_DONE;
               end else if (at_limit_d) begin
                  resp_err_q <= 1'b1;
                  state_q    <= ST_DONE;
               end else begin
                  iter_count_q <= iter_count_q + 1'b1;
               end
            end
            ST_DONE: begin
               if (resp_ready) begin
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign req_ready  = (state_q == ST_IDLE);
   assign busy       = (state_q != ST_IDLE);
   assign resp_valid = (state_q == ST_DONE);
   assign resp_err   = resp_err_q;
   assign iter_count = iter_count_q;
   assign data_out   = data_out_q;
   assign ld_a       = ld_a_q;
   assign clr_p      = clr_p_q;
   assign ld_b       = ld_b_q;
   assign ld_p       = add_step_d;
   assign dec_b      = add_step_d;

endmodule : mtra_controller
`default_nettype wire

// File: doc/mtra_controller.md
Name: mtra_controller

Overview:
FSM that sequences the repeated-addition multiplier datapath. Accepts an operand pair over a valid/ready request channel and drives the shared 16-bit data bus and the datapath strobes: load A, clear P, load B, then add/decrement until eqz. Reports completion, iteration count and a timeout error over a valid/ready response channel. Sits between the requesting logic and the datapath; the product itself is read from the datapath P register.

Parameters:
DATA_W, 16, operand / data bus width; matches datapath registers.
MAX_ITER, 65535, add iterations allowed before abort with error; must be <= 2^DATA_W-1.

Ports:
clk  in  1  clock; all state on rising edge
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
req_valid  in  1  operand pair offered
req_ready  out  1  controller can accept (high only in IDLE)
a_in  in  DATA_W  multiplicand
b_in  in  DATA_W  multiplier (add count)
resp_valid  out  1  operation finished; held until resp_ready
resp_ready  in  1  consumer accepts response
resp_err  out  1  valid with resp_valid; 1 = timeout abort
iter_count  out  DATA_W  adds performed in the current/last operation
busy  out  1  high in any state except IDLE
data_out  out  DATA_W  drives datapath data_in
ld_a, ld_b, ld_p, clr_p, dec_b  out  1 each  datapath strobes
eqz  in  1  datapath counter-zero flag (combinational from counter)

Behaviour:
- States: IDLE, LOAD_A, LOAD_B, ADD, DONE.
- Reset (async, rst_n=0): state IDLE; all strobes 0; data_out 0; resp_valid 0; resp_err 0; iter_count 0; busy 0; internal operand regs 0. Reset mid-operation abandons it; no response is produced.
- IDLE: req_ready=1. On req_valid&&req_ready: capture a_in, b_in internally, clear iter_count, go LOAD_A. Requester may drop operands after the handshake.
- LOAD_A (1 cycle): data_out=A, ld_a=1, clr_p=1 -> LOAD_B.
- LOAD_B (1 cycle): data_out=B, ld_b=1 -> ADD.
- ADD: eqz reflects the current counter value.
  - eqz=1: no strobes -> DONE, resp_err=0.
  - eqz=0 and iter_count==MAX_ITER: no strobes -> DONE, resp_err=1.
  - otherwise: ld_p=1, dec_b=1 in the same cycle, iter_count+1, stay in ADD.
- DONE: resp_valid=1, resp_err and iter_count stable. On resp_ready -> IDLE. resp_valid deasserts the cycle after the handshake.
- Latency: handshake edge -> resp_valid high after 3+B cycles (LOAD_A, LOAD_B, B add cycles, final check cycle). B=0 gives 3 cycles and no ld_p.
- Strobes are mutually exclusive apart from the pairs ld_a+clr_p and ld_p+dec_b. Strobes are 0 in IDLE and DONE.
- data_out holds its last driven value outside LOAD_A/LOAD_B. The datapath ignores data_out without a load strobe.
- req_valid during busy is ignored (req_ready=0). Nothing is queued.
- iter_count never wraps: it is bounded by MAX_ITER.
- The width of A*B is the datapath's concern. The controller does not detect overflow.

Decomposition:
- Package mtra_pkg: state enum (IDLE, LOAD_A, LOAD_B, ADD, DONE) and DATA_W default constant.
- Single module. No sub-module is warranted; the iteration counter stays inline.

Test Plan:
- A=7, B=3, resp_ready=1, controller wired to datapath -> ld_p/dec_b high for exactly 3 consecutive cycles; resp_valid 6 cycles after the handshake; iter_count=3; resp_err=0; P=21.
- A=9, B=0 -> no ld_p or dec_b pulses; resp_valid 3 cycles after the handshake; iter_count=0; P=0.
- A=5, B=2, resp_ready held low 5 cycles in DONE -> resp_valid, iter_count=2 and resp_err=0 stable all 5 cycles; req_ready=0; a new req_valid is ignored until resp_ready.
- MAX_ITER=4, A=1, B=10 -> exactly 4 ld_p pulses; resp_err=1; iter_count=4.
- rst_n low during ADD (A=3, B=8, after 2 adds) -> all strobes 0 immediately (async); IDLE and req_ready=1 after release; no resp_valid.
- Back-to-back: (A=2, B=2) then (A=4, B=1) offered continuously -> second accepted the cycle after the first response handshake; P=4, then P=4; iter_count 2, then 1.
